spi_write_sequencer: RTL and testbench
======================================

// Module: spi_write_sequencer
// PURPOSE
//   SPI controller (mode 0) that issues register writes to the on-chip SPI register peripheral.
//   Up to NUM_REQ requesters submit (addr, data) write commands over valid/ready handshakes.
//   A round-robin arbiter shares the single SPI link between them; each command becomes one 16-bit frame.
//   The block drives sclk/copi/cs_n directly into the peripheral's inputs.
// PARAMETERS
//   NUM_REQ       4   number of requesters (>=1)
//   CLK_DIV       4   clk cycles per sclk half-period (>=2)
//   CS_GAP        2   clk cycles cs_n held high between frame end and commit pulse (>=1)
//   COMMIT_PULSE  1   1: emit one sclk pulse with cs_n high after each frame (peripheral commits on it)
// PORTS
//   clk        in   1          system clock; only clock in the block
//   rst        in   1          asynchronous, active-high reset
//   req_valid  in   NUM_REQ    per-requester command valid
//   req_addr   in   NUM_REQ*7  per-requester register address, requester i at [7i+6:7i]
//   req_data   in   NUM_REQ*8  per-requester write data, requester i at [8i+7:8i]
//   req_ready  out  NUM_REQ    one-hot accept strobe
//   grant_id   out  clog2(NUM_REQ) (min 1)  requester currently being served
//   busy       out  1          high from accept until return to IDLE
//   done       out  1          1-cycle pulse when a frame (incl. commit) completes
//   addr_err   out  1          1-cycle pulse when an out-of-range address is accepted and dropped
//   sclk       out  1          SPI clock, idle low
//   copi       out  1          SPI data, MSB first
//   cs_n       out  1          SPI chip select, active low
// BEHAVIOUR
//   Reset: all outputs go low immediately, except cs_n, which goes high; rr pointer=0; state=IDLE.
//   Reset mid-frame abandons the frame with no commit pulse; the peripheral is reset by the same system reset.
//   Handshake: transfer when req_valid[i] & req_ready[i]. req_ready is asserted only in IDLE, combinationally, to the single winner.
//   Requesters hold valid/addr/data stable until accepted. valid may drop without penalty before acceptance.
//   Arbitration: round-robin starting at pointer. On accept, pointer <= grant+1 (mod NUM_REQ). grant_id is registered on accept.
//   Frame: bit15=1 (write), [14:8]=addr, [7:0]=data, shifted MSB first.
//   Address check: addr >= NUM_REGS (5) is accepted but not sent; addr_err pulses the next cycle; stays IDLE; no done.
//   FSM: IDLE -> SHIFT -> HOLD -> GAP -> COMMIT -> IDLE.
//     IDLE: an accept on cycle t gives cs_n=0 and copi=bit15 from t+1.
//     SHIFT: per bit, sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. copi updates only at the start of each low phase.
//       Bit counter runs 15 down to 0; leave SHIFT after the high phase of bit0.
//     HOLD: sclk=0, cs_n=0 for CLK_DIV cycles; then cs_n=1, copi=0.
//       Total cs_n low = 33*CLK_DIV cycles (132 at default).
//     GAP: cs_n=1 for CS_GAP cycles.
//     COMMIT: sclk high CLK_DIV, then low CLK_DIV, with cs_n=1. Skipped if COMMIT_PULSE=0.
//       done pulses on the last cycle; IDLE follows.
//   Back-to-back: the earliest next accept is the cycle after done. The next cs_n fall is therefore >= CS_GAP+2*CLK_DIV+1 cycles after cs_n rise.
//   Simultaneous valid on all inputs: exactly one grant per frame, fair rotation.
//   Outputs sclk/copi/cs_n are driven directly from flops (glitch-free).
// STRUCTURE
//   Header spi_defs.vh: FRAME_BITS=16, ADDR_W=7, DATA_W=8, NUM_REGS=5, WRITE_BIT=1'b1, FSM state localparams.
//   Sub-module rr_arbiter (NUM_REQ): inputs valid, pointer, enable; outputs one-hot grant and index. Purely combinational.
//   Top holds the FSM, half-period divider counter, bit counter, 16-bit shift register and rr pointer.
// TESTING (bench instantiates this block driving the SPI register peripheral)
//   1. Req0 writes addr 0x02, data 0xA5 (default parameters).
//      -> frame 1_0000010_10100101 is sampled on 16 sclk rises; cs_n is low for 132 cycles.
//      -> one commit pulse follows, then done; peripheral reg_2=0xA5.
//   2. All 4 valid from reset with addrs 0..3 -> grants in order 0,1,2,3.
//      -> a re-assertion of all 4 then gives 0,1,2,3 again; each done is observed once.
//   3. Req1 with addr 0x05 -> req_ready[1] for 1 cycle, then addr_err=1 for 1 cycle.
//      -> cs_n stays 1, no sclk edge, no done.
//   4. rst asserted during the high phase of bit7 -> cs_n=1 and sclk=0 asynchronously.
//      -> after release, req2 addr 0x04 data 0x3C yields a clean full frame; reg_4=0x3C.
//   5. Req3 holds valid for two commands -> the second cs_n fall is >= 11 cycles after the first cs_n rise (defaults).
//   6. CLK_DIV=2, COMMIT_PULSE=0 -> sclk period is 4 clk, cs_n low for 66 cycles, no sclk edge while cs_n is high.

Source files
------------

// File: rtl/spi_write_sequencer_pkg.sv
// Shared constants, FSM state type and frame builder for the SPI write sequencer.
package spi_write_sequencer_pkg;

  localparam int   FRAME_BITS = 16;
  localparam int   ADDR_W     = 7;
  localparam int   DATA_W     = 8;
  localparam int   NUM_REGS   = 5;
  localparam logic WRITE_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
    ST_COMMIT
  } state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                        input logic [DATA_W-1:0] data);
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_write_sequencer_if.sv
// Requester-side command bus: flattened per-requester valid/addr/data with one-hot ready.
interface spi_write_sequencer_if
  import spi_write_sequencer_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/spi_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after the pointer wins.
module spi_write_sequencer_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   pointer_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   index_o
);

  logic [IDX_W-1:0] cand_idx [NUM_REQ];
  logic             found;

  // Candidate k is the requester k positions after the pointer, wrapping at NUM_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((int'(pointer_i) + gi) % NUM_REQ);
    end
  endgenerate

  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (enable_i && !found && valid_i[cand_idx[k]]) begin
        found                = 1'b1;
        grant_o[cand_idx[k]] = 1'b1;
        index_o              = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/spi_write_sequencer.sv
// Mode-0 SPI master turning arbitrated (addr, data) write commands into 16-bit frames plus commit pulse.
module spi_write_sequencer
  import spi_write_sequencer_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  CLK_DIV      = 4,
  parameter int  CS_GAP       = 2,
  parameter int  COMMIT_PULSE = 1,
  localparam int GID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_write_sequencer_if.slave       req_if,
  output logic [GID_W-1:0]           grant_id_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       addr_err_o,
  output logic                       sclk_o,
  output logic                       copi_o,
  output logic                       cs_n_o
);

  localparam int               DIV_MAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int               DIV_W    = $clog2(DIV_MAX + 1);
  localparam int               BIT_W    = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CS_GAP - 1);

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-2:0]   shreg_q, shreg_d;
  logic                    phase_hi_q, phase_hi_d;
  logic [GID_W-1:0]        ptr_q, ptr_d;
  logic [GID_W-1:0]        grant_id_q, grant_id_d;
  logic                    busy_q, busy_d;
  logic                    addr_err_q, addr_err_d;
  logic                    sclk_q, sclk_d;
  logic                    copi_q, copi_d;
  logic                    cs_n_q, cs_n_d;

  logic                    arb_en;
  logic [NUM_REQ-1:0]      arb_grant;
  logic [GID_W-1:0]        arb_idx;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_data;
  logic [FRAME_BITS-1:0]   frame;
  logic                    accept;
  logic                    addr_ok;
  logic                    div_last;
  logic                    gap_last;
  logic                    bit_last;

  spi_write_sequencer_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_arb (
    .valid_i   (req_if.req_valid),
    .pointer_i (ptr_q),
    .enable_i  (arb_en),
    .grant_o   (arb_grant),
    .index_o   (arb_idx)
  );

  assign sel_addr = req_if.req_addr[arb_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_if.req_data[arb_idx*DATA_W +: DATA_W];
  assign frame    = build_frame(sel_addr, sel_data);
  assign accept   = |arb_grant;
  assign addr_ok  = (sel_addr < ADDR_W'(NUM_REGS));
  assign div_last = (div_cnt_q == DIV_LAST);
  assign gap_last = (div_cnt_q == GAP_LAST);
  assign bit_last = (bit_cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept && addr_ok) state_d = ST_SHIFT;
      ST_SHIFT:  if (phase_hi_q && div_last && bit_last) state_d = ST_HOLD;
      ST_HOLD:   if (div_last) state_d = ST_GAP;
      ST_GAP:    if (gap_last) state_d = (COMMIT_PULSE != 0) ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: if (!phase_hi_q && div_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Ready is held off during reset so no handshake can complete while the block is cleared.
  always_comb begin
    arb_en = (state_q == ST_IDLE) && !rst;
    done_o = ((state_q == ST_COMMIT) && !phase_hi_q && div_last) ||
             ((COMMIT_PULSE == 0) && (state_q == ST_GAP) && gap_last);
  end

  assign req_if.req_ready = arb_grant;

  always_comb begin
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    phase_hi_d = phase_hi_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    addr_err_d = 1'b0;
    sclk_d     = sclk_q;
    copi_d     = copi_q;
    cs_n_d     = cs_n_q;
    unique case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        if (accept) begin
          grant_id_d = arb_idx;
          ptr_d      = (arb_idx == GID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          if (addr_ok) begin
            shreg_d    = frame[FRAME_BITS-2:0];
            copi_d     = frame[FRAME_BITS-1];
            cs_n_d     = 1'b0;
            sclk_d     = 1'b0;
            phase_hi_d = 1'b0;
            bit_cnt_d  = BIT_W'(FRAME_BITS - 1);
            busy_d     = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (!phase_hi_q) begin
            sclk_d     = 1'b1;
            phase_hi_d = 1'b1;
          end else begin
            sclk_d     = 1'b0;
            phase_hi_d = 1'b0;
            // Next bit is presented at the start of the following low phase.
            if (!bit_last) begin
              bit_cnt_d = bit_cnt_q - 1'b1;
              copi_d    = shreg_q[FRAME_BITS-2];
              shreg_d   = {shreg_q[FRAME_BITS-3:0], 1'b0};
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (div_last) begin
          div_cnt_d = '0;
          cs_n_d    = 1'b1;
          copi_d    = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          div_cnt_d = '0;
          if (COMMIT_PULSE != 0) begin
            sclk_d     = 1'b1;
            phase_hi_d = 1'b1;
          end else begin
            busy_d = 1'b0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (phase_hi_q) begin
            sclk_d     = 1'b0;
            phase_hi_d = 1'b0;
          end else begin
            busy_d = 1'b0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      phase_hi_q <= 1'b0;
      ptr_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
      sclk_q     <= 1'b0;
      copi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      phase_hi_q <= phase_hi_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
      sclk_q     <= sclk_d;
      copi_q     <= copi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign grant_id_o = grant_id_q;
  assign busy_o     = busy_q;
  assign addr_err_o = addr_err_q;
  assign sclk_o     = sclk_q;
  assign copi_o     = copi_q;
  assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_spi_write_sequencer.sv
// Directed bench: two sequencer instances (default and fast/no-commit) with a behavioural SPI register peripheral.
module tb_spi_write_sequencer;
  import spi_write_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  spi_write_sequencer_if #(.NUM_REQ(4)) ifa ();
  spi_write_sequencer_if #(.NUM_REQ(4)) ifb ();

  logic [1:0] gid_a, gid_b;
  logic busy_a, done_a, err_a, sclk_a, copi_a, cs_n_a;
  logic busy_b, done_b, err_b, sclk_b, copi_b, cs_n_b;

  spi_write_sequencer #(.NUM_REQ(4), .CLK_DIV(4), .CS_GAP(2), .COMMIT_PULSE(1)) dut_a (
    .clk(clk), .rst(rst), .req_if(ifa), .grant_id_o(gid_a), .busy_o(busy_a), .done_o(done_a),
    .addr_err_o(err_a), .sclk_o(sclk_a), .copi_o(copi_a), .cs_n_o(cs_n_a)
  );

  spi_write_sequencer #(.NUM_REQ(4), .CLK_DIV(2), .CS_GAP(2), .COMMIT_PULSE(0)) dut_b (
    .clk(clk), .rst(rst), .req_if(ifb), .grant_id_o(gid_b), .busy_o(busy_b), .done_o(done_b),
    .addr_err_o(err_b), .sclk_o(sclk_b), .copi_o(copi_b), .cs_n_o(cs_n_b)
  );

  // SPI register peripheral on instance A: shifts on sclk rise under cs_n, commits on a rise with cs_n high.
  logic [15:0] shift_a;
  int          bits_a;
  logic [7:0]  regs_a [0:4];
  always @(posedge sclk_a or posedge rst) begin
    if (rst) begin
      shift_a <= '0;
      bits_a  <= 0;
      for (int i = 0; i < 5; i++) regs_a[i] <= '0;
    end else if (!cs_n_a) begin
      shift_a <= {shift_a[14:0], copi_a};
      bits_a  <= bits_a + 1;
    end else begin
      if (bits_a == 16 && shift_a[15] && shift_a[14:8] < 7'd5) regs_a[shift_a[10:8]] <= shift_a[7:0];
      bits_a <= 0;
    end
  end

  int lo_a = 0, hi_a = 0, lo_b = 0, hi_b = 0;
  always @(posedge sclk_a) if (cs_n_a) hi_a <= hi_a + 1; else lo_a <= lo_a + 1;
  always @(posedge sclk_b) if (cs_n_b) hi_b <= hi_b + 1; else lo_b <= lo_b + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req_a(input int i, input logic [6:0] a, input logic [7:0] d);
    ifa.req_valid[i]       = 1'b1;
    ifa.req_addr[i*7 +: 7] = a;
    ifa.req_data[i*8 +: 8] = d;
  endtask

  // Waits (bounded) for a ready strobe, lets the accept edge pass, returns at the following negedge.
  task automatic accept_a(output int idx);
    idx = -1;
    #1;
    for (int n = 0; n < 50; n++) begin
      if (ifa.req_ready != '0) begin
        for (int i = 0; i < 4; i++) if (ifa.req_ready[i]) idx = i;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("accept_onehot", 32'($countones(ifa.req_ready)), 32'd1);
    if (idx >= 0) begin
      @(posedge clk);
      @(negedge clk);
      $display("txn: requester %0d accepted, grant_id=%0d", idx, gid_a);
    end
  endtask

  task automatic frame_a(output int cs_low, output int dones);
    cs_low = 0;
    dones  = 0;
    for (int n = 0; n < 600; n++) begin
      if (!cs_n_a) cs_low++;
      if (done_a) dones++;
      if (!busy_a) break;
      @(negedge clk);
    end
    $display("txn: frame end cs_low=%0d done=%0d frame=0x%04h", cs_low, dones, shift_a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cs_low, dones, base_lo, base_hi, cnt, gap, last_n, periods, bad_p;
    logic prev_s;

    ifa.req_valid = '0; ifa.req_addr = '0; ifa.req_data = '0;
    ifb.req_valid = '0; ifb.req_addr = '0; ifb.req_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, with all requesters valid to show ready is held off.
    ifa.req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(ifa.req_ready), 32'h0);
    chk("rst_cs_n", 32'(cs_n_a), 32'h1);
    chk("rst_sclk", 32'(sclk_a), 32'h0);
    chk("rst_copi", 32'(copi_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    chk("rst_gid", 32'(gid_a), 32'h0);
    chk("rst_cs_n_b", 32'(cs_n_b), 32'h1);
    ifa.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: single write addr 2 data A5.
    set_req_a(0, 7'h02, 8'hA5);
    #1;
    chk("t1_ready", 32'(ifa.req_ready), 32'h1);
    base_lo = lo_a; base_hi = hi_a;
    @(posedge clk);
    @(negedge clk);
    ifa.req_valid[0] = 1'b0;
    chk("t1_cs_n_t1", 32'(cs_n_a), 32'h0);
    chk("t1_copi_bit15", 32'(copi_a), 32'h1);
    chk("t1_gid", 32'(gid_a), 32'h0);
    chk("t1_busy", 32'(busy_a), 32'h1);
    frame_a(cs_low, dones);
    chk("t1_cs_low", 32'(cs_low), 32'd132);
    chk("t1_data_rises", 32'(lo_a - base_lo), 32'd16);
    chk("t1_frame", 32'(shift_a), 32'h82A5);
    chk("t1_commit_rises", 32'(hi_a - base_hi), 32'd1);
    chk("t1_done", 32'(dones), 32'd1);
    chk("t1_reg2", 32'(regs_a[2]), 32'hA5);

    // 2: all four valid from reset, two rounds.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) set_req_a(i, 7'(i), 8'(16 * (r + 1) + i));
      for (int k = 0; k < 4; k++) begin
        accept_a(idx);
        chk($sformatf("t2_grant_r%0d_k%0d", r, k), 32'(idx), 32'(k));
        chk($sformatf("t2_gid_r%0d_k%0d", r, k), 32'(gid_a), 32'(k));
        if (idx >= 0) ifa.req_valid[idx] = 1'b0;
        frame_a(cs_low, dones);
        chk($sformatf("t2_done_r%0d_k%0d", r, k), 32'(dones), 32'd1);
      end
      for (int i = 0; i < 4; i++)
        chk($sformatf("t2_reg%0d_r%0d", i, r), 32'(regs_a[i]), 32'(16 * (r + 1) + i));
    end

    // 3: out-of-range address is accepted and dropped.
    set_req_a(1, 7'h05, 8'h77);
    #1;
    chk("t3_ready", 32'(ifa.req_ready), 32'h2);
    base_lo = lo_a; base_hi = hi_a;
    @(posedge clk);
    @(negedge clk);
    ifa.req_valid[1] = 1'b0;
    #1;
    chk("t3_addr_err", 32'(err_a), 32'h1);
    chk("t3_cs_n", 32'(cs_n_a), 32'h1);
    chk("t3_busy", 32'(busy_a), 32'h0);
    chk("t3_ready_drop", 32'(ifa.req_ready), 32'h0);
    @(negedge clk);
    chk("t3_addr_err_pulse", 32'(err_a), 32'h0);
    cnt = 0; dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (!cs_n_a) cnt++;
      if (done_a) dones++;
      @(negedge clk);
    end
    chk("t3_cs_low", 32'(cnt), 32'd0);
    chk("t3_done", 32'(dones), 32'd0);
    chk("t3_sclk_edges", 32'((lo_a - base_lo) + (hi_a - base_hi)), 32'd0);

    // 4: reset in the high phase of bit 7, then a clean frame.
    set_req_a(0, 7'h01, 8'h5A);
    base_lo = lo_a;
    accept_a(idx);
    ifa.req_valid[0] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (lo_a - base_lo == 9) break;
      @(negedge clk);
    end
    chk("t4_reach_bit7", 32'(lo_a - base_lo), 32'd9);
    chk("t4_sclk_high", 32'(sclk_a), 32'h1);
    base_hi = hi_a;
    #2 rst = 1'b1;
    #1;
    chk("t4_async_cs_n", 32'(cs_n_a), 32'h1);
    chk("t4_async_sclk", 32'(sclk_a), 32'h0);
    chk("t4_async_busy", 32'(busy_a), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (!cs_n_a) cnt++;
      @(negedge clk);
    end
    chk("t4_idle_after_rst", 32'(cnt), 32'd0);
    chk("t4_no_commit", 32'(hi_a - base_hi), 32'd0);
    set_req_a(2, 7'h04, 8'h3C);
    accept_a(idx);
    chk("t4_grant", 32'(idx), 32'd2);
    chk("t4_gid", 32'(gid_a), 32'd2);
    ifa.req_valid[2] = 1'b0;
    frame_a(cs_low, dones);
    chk("t4_cs_low", 32'(cs_low), 32'd132);
    chk("t4_frame", 32'(shift_a), 32'h843C);
    chk("t4_done", 32'(dones), 32'd1);
    chk("t4_reg4", 32'(regs_a[4]), 32'h3C);
    chk("t4_reg1_untouched", 32'(regs_a[1]), 32'h0);

    // 5: requester 3 issues two commands back to back.
    set_req_a(3, 7'h00, 8'h11);
    accept_a(idx);
    chk("t5_grant", 32'(idx), 32'd3);
    set_req_a(3, 7'h01, 8'h22);
    dones = 0;
    for (int n = 0; n < 300; n++) begin
      if (cs_n_a) break;
      @(negedge clk);
    end
    gap = 0;
    for (int n = 0; n < 200; n++) begin
      if (!cs_n_a) break;
      gap++;
      if (done_a) dones++;
      @(negedge clk);
    end
    ifa.req_valid[3] = 1'b0;
    chk("t5_gap", 32'(gap), 32'd11);
    chk("t5_first_done", 32'(dones), 32'd1);
    chk("t5_gid2", 32'(gid_a), 32'd3);
    frame_a(cs_low, dones);
    chk("t5_cs_low2", 32'(cs_low), 32'd132);
    chk("t5_done2", 32'(dones), 32'd1);
    chk("t5_reg0", 32'(regs_a[0]), 32'h11);
    chk("t5_reg1", 32'(regs_a[1]), 32'h22);

    // 6: CLK_DIV=2, no commit pulse, on instance B.
    ifb.req_valid[0] = 1'b1;
    ifb.req_addr[6:0] = 7'h03;
    ifb.req_data[7:0] = 8'h99;
    #1;
    chk("t6_ready", 32'(ifb.req_ready), 32'h1);
    base_lo = lo_b; base_hi = hi_b;
    @(posedge clk);
    @(negedge clk);
    ifb.req_valid[0] = 1'b0;
    cs_low = 0; dones = 0; last_n = -1; periods = 0; bad_p = 0; prev_s = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!cs_n_b) cs_low++;
      if (done_b) dones++;
      if (sclk_b && !prev_s) begin
        if (last_n >= 0) begin
          periods++;
          if (n - last_n != 4) bad_p++;
        end
        last_n = n;
      end
      prev_s = sclk_b;
      if (!busy_b) break;
      @(negedge clk);
    end
    for (int n = 0; n < 20; n++) @(negedge clk);
    $display("txn: fast frame cs_low=%0d periods=%0d done=%0d", cs_low, periods, dones);
    chk("t6_cs_low", 32'(cs_low), 32'd66);
    chk("t6_periods", 32'(periods), 32'd15);
    chk("t6_period_len", 32'(bad_p), 32'd0);
    chk("t6_data_rises", 32'(lo_b - base_lo), 32'd16);
    chk("t6_no_hi_edges", 32'(hi_b - base_hi), 32'd0);
    chk("t6_done", 32'(dones), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
